score_display_draw: RTL and testbench
=====================================

// Module: score_display_draw
// PURPOSE
//  Renders the four BCD score digits (thousands..ones) as a scaled bitmap overlay on the VGA frame.
//  Reads the score from the scoring block and samples the digits once per frame, so a mid-frame update causes no tearing.
//  Outputs drawingRequest/RGBout to the object mux, 2 clk after pixelX/pixelY.
// PARAMETERS
//  TOP_LEFT_X   16     X of leftmost (thousands) digit box
//  TOP_LEFT_Y   8      Y of top of all digit boxes
//  SCALE_SHIFT  1      glyph scale = 2**SCALE_SHIFT; digit box = (8<<S) x (16<<S)
//  DIGIT_GAP    4      blank pixels between adjacent digit boxes
//  SCORE_COLOR  8'hFF  normal digit colour (RGB332)
//  FLASH_COLOR  8'hE0  flash colour (used only with SCORE_FLASH_EN)
//  FLASH_FRAMES 30     frames of flashing after a score change
// PORTS
//  clk             in   1   pixel clock
//  resetN          in   1   asynchronous, active-low reset
//  startOfFrame    in   1   one-clk pulse at frame start; triggers the digit sample
//  pixelX          in   11  current pixel X, advances once per clk
//  pixelY          in   11  current pixel Y
//  score1..score1000 in 4 each  BCD digits from the score counter
//  drawingRequest  out  1   1 = glyph pixel lit at the pixel presented 2 clk earlier
//  RGBout          out  8   colour for that pixel; 8'h00 when drawingRequest=0
// BEHAVIOUR
//  Reset: shadow digits=0, pipeline valid=0, drawingRequest=0, RGBout=0, flash counter=0. Screen then shows "0".
//  Snapshot: on a clk with startOfFrame=1, the shadow registers load all four digits. Otherwise they hold.
//   A pixel sampled on the same edge as startOfFrame uses the pre-update shadow.
//  Digit clamp: a shadow value 10..15 is drawn as glyph '9' (saturated display).
//  Leading-zero blanking, evaluated on the shadow digits:
//   - thousands is blanked if it is 0.
//   - hundreds is blanked if thousands and hundreds are both 0.
//   - tens is blanked if the upper three digits are all 0.
//   - ones is always drawn.
//  Layout: digit i (0=thousands..3=ones) spans the following; gaps and everything outside are never drawn.
//   - X in [TOP_LEFT_X + i*(W+DIGIT_GAP), +W), where W = 8<<SCALE_SHIFT.
//   - Y in [TOP_LEFT_Y, TOP_LEFT_Y + (16<<SCALE_SHIFT)).
//  Pipeline, 2-cycle latency, no stalls:
//   - Stage 1 registers inside-box, digit index, glyph digit (after clamp/blank) and local col/row.
//     Local col/row are the pixel offsets within the box >> SCALE_SHIFT.
//   - Stage 2 registers the glyph ROM bit; drawingRequest = inside & !blank & romBit.
//  Subtraction for local coords is done at 11 bits. Pixels left of or above the box must fail the range compare, never wrap into it.
//  Reset mid-frame: outputs go 0 asynchronously. Drawing resumes 2 clk after release, showing "0" until the next startOfFrame.
// CONFIGURATION
//  SCORE_FLASH_EN defined:
//   - At a snapshot where new digits != previous shadow, the counter loads FLASH_FRAMES.
//   - Otherwise the counter decrements on each startOfFrame, saturating at 0.
//   - Lit pixels use FLASH_COLOR while (cnt!=0 && cnt[2]), else SCORE_COLOR.
//  SCORE_FLASH_EN undefined: no counter logic; lit pixels are always SCORE_COLOR.
// STRUCTURE
//  score_pkg holds:
//   - typedef logic [3:0] bcd_digit_t
//   - GLYPH_W=8, GLYPH_H=16, NUM_DIGITS=4
//   - colour constants for the SCORE_COLOR/FLASH_COLOR defaults
//  Sub-module score_glyph_rom takes digit[3:0], row[3:0], col[2:0] and returns a registered 1-bit pixel.
//   It holds 10 glyphs of 8x16 as a case-based ROM and supplies the stage-2 register.
// TESTING (defaults: boxes 16x32; X ranges 16-31, 36-51, 56-71, 76-91; Y 8-39)
//  1 Reset, one startOfFrame, scan rows 8..39 over X 16..91:
//    - lit pixels appear only in 76..91 with glyph '0', RGB=8'hFF.
//    - drawingRequest rises exactly 2 clk after the matching pixelX.
//  2 score1000..1=0,1,0,5 then startOfFrame: thousands box dark; "105" drawn. Tens box shows '0' (not blanked).
//  3 Change score1 from 5 to 7 mid-frame with no startOfFrame: ones still '5' through end of frame; '7' after next pulse.
//  4 Pixels (32,20), (52,20), (92,20), (20,7), (20,40), (0,0): drawingRequest=0, RGBout=8'h00.
//  5 score1000=4'hC, others 0: thousands box draws glyph '9'; lower three digits drawn as '0'.
//  6 SCORE_FLASH_EN, score changes at frame N:
//    - lit pixels use 8'hE0 on frames where cnt[2]=1, otherwise 8'hFF.
//    - steady 8'hFF from frame N+30.
//    - assert resetN low mid-line: outputs 0 within the same cycle.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score overlay: BCD digit type, glyph geometry,
// default colours and the saturating digit clamp.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;
    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] DEF_SCORE_COLOR = 8'hFF;
    localparam logic [7:0] DEF_FLASH_COLOR = 8'hE0;

    // Out-of-range BCD values saturate to '9' on screen
    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
        if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/score_glyph_rom.sv
// 8x16 glyph ROM for digits 0..9 with a registered output pixel; row 0 is the top line,
// col 0 is the MSB of each row byte. 'visible' gates the pixel so the register is the draw decision.
module score_glyph_rom
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       visible,
    input  bcd_digit_t digit,
    input  logic [3:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [127:0] glyph_s;
    logic [6:0]   bit_idx_s;

    // Glyph bitmap select, 16 row bytes packed top row first
    always_comb begin
        case (digit)
            4'd0:    glyph_s = 128'h00003C66_666E7666_66666666_3C000000;
            4'd1:    glyph_s = 128'h00001838_78181818_18181818_7E000000;
            4'd2:    glyph_s = 128'h00003C66_06060C18_30606066_7E000000;
            4'd3:    glyph_s = 128'h00003C66_06061C06_06060666_3C000000;
            4'd4:    glyph_s = 128'h00000C1C_3C6CCCCC_FE0C0C0C_1E000000;
            4'd5:    glyph_s = 128'h00007E60_60607C06_06060666_3C000000;
            4'd6:    glyph_s = 128'h00001C30_60607C66_66666666_3C000000;
            4'd7:    glyph_s = 128'h00007E66_06060C18_18181818_18000000;
            4'd8:    glyph_s = 128'h00003C66_66663C66_66666666_3C000000;
            4'd9:    glyph_s = 128'h00003C66_66663E06_0606060C_38000000;
            default: glyph_s = 128'h0;
        endcase
    end

    assign bit_idx_s = 7'd127 - {row, col};

    // Stage-2 pixel register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixel <= 1'b0;
        end else begin
            pixel <= visible & glyph_s[bit_idx_s];
        end
    end

endmodule

// File: rtl/score_display_draw.sv
// Four-digit BCD score overlay with frame-synchronous digit snapshot and 2-clk pixel pipeline.
// Optional SCORE_FLASH_EN macro enables colour flashing for FLASH_FRAMES frames after a score change.
module score_display_draw
    import score_pkg::*;
#(
    parameter int         TOP_LEFT_X   = 16,
    parameter int         TOP_LEFT_Y   = 8,
    parameter int         SCALE_SHIFT  = 1,
    parameter int         DIGIT_GAP    = 4,
    parameter logic [7:0] SCORE_COLOR  = DEF_SCORE_COLOR,
    parameter logic [7:0] FLASH_COLOR  = DEF_FLASH_COLOR,
    parameter int         FLASH_FRAMES = 30
)(
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  bcd_digit_t  score1,
    input  bcd_digit_t  score10,
    input  bcd_digit_t  score100,
    input  bcd_digit_t  score1000,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    localparam int          BOX_W = GLYPH_W << SCALE_SHIFT;
    localparam int          BOX_H = GLYPH_H << SCALE_SHIFT;
    localparam logic [10:0] Y_TOP = 11'(TOP_LEFT_Y);
    localparam logic [10:0] Y_BOT = 11'(TOP_LEFT_Y + BOX_H);

    function automatic logic [10:0] box_x0(input int i);
        return 11'(TOP_LEFT_X + i * (BOX_W + DIGIT_GAP));
    endfunction

    bcd_digit_t        shadow_r [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] hit_s;
    logic              in_y_s;
    logic              inside_s;
    logic [1:0]        idx_s;
    logic [10:0]       dx_s;
    logic [10:0]       dy_s;
    bcd_digit_t        digit_s;
    logic              blank_s;
    logic [2:0]        col_s;
    logic [3:0]        row_s;
    logic              flash_on_s;
    logic [7:0]        color_s;

    logic              inside1_r;
    logic              blank1_r;
    bcd_digit_t        digit1_r;
    logic [2:0]        col1_r;
    logic [3:0]        row1_r;
    logic [7:0]        color1_r;
    logic [7:0]        color2_r;
    logic              pixel_s;

    // Digit snapshot, index 0 = thousands
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_r[i] <= 4'd0;
            end
        end else if (startOfFrame) begin
            shadow_r[0] <= score1000;
            shadow_r[1] <= score100;
            shadow_r[2] <= score10;
            shadow_r[3] <= score1;
        end
    end

`ifdef SCORE_FLASH_EN
    logic [7:0] flash_cnt_r;
    logic       digits_changed_s;

    assign digits_changed_s = ({score1000, score100, score10, score1} !=
                               {shadow_r[0], shadow_r[1], shadow_r[2], shadow_r[3]});

    // Flash counter: reload on a changed snapshot, otherwise count frames down to 0
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flash_cnt_r <= 8'd0;
        end else if (startOfFrame) begin
            if (digits_changed_s) begin
                flash_cnt_r <= 8'(FLASH_FRAMES);
            end else if (flash_cnt_r != 8'd0) begin
                flash_cnt_r <= flash_cnt_r - 8'd1;
            end
        end
    end

    assign flash_on_s = (flash_cnt_r != 8'd0) && flash_cnt_r[2];
`else
    assign flash_on_s = 1'b0;
`endif

    assign color_s = flash_on_s ? FLASH_COLOR : SCORE_COLOR;

    // Box hit test, digit selection and local glyph coordinates; compares are on
    // unwrapped coordinates so pixels left of / above a box never alias into it
    always_comb begin
        in_y_s = (pixelY >= Y_TOP) && (pixelY < Y_BOT);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hit_s[i] = in_y_s && (pixelX >= box_x0(i)) && (pixelX < box_x0(i) + 11'(BOX_W));
        end
        inside_s = |hit_s;
        if (hit_s[3]) begin
            idx_s = 2'd3;
        end else if (hit_s[2]) begin
            idx_s = 2'd2;
        end else if (hit_s[1]) begin
            idx_s = 2'd1;
        end else begin
            idx_s = 2'd0;
        end
        dx_s    = pixelX - box_x0(int'(idx_s));
        dy_s    = pixelY - Y_TOP;
        col_s   = 3'(dx_s >> SCALE_SHIFT);
        row_s   = 4'(dy_s >> SCALE_SHIFT);
        digit_s = clamp_digit(shadow_r[idx_s]);
        case (idx_s)
            2'd0:    blank_s = (shadow_r[0] == 4'd0);
            2'd1:    blank_s = (shadow_r[0] == 4'd0) && (shadow_r[1] == 4'd0);
            2'd2:    blank_s = (shadow_r[0] == 4'd0) && (shadow_r[1] == 4'd0) &&
                               (shadow_r[2] == 4'd0);
            default: blank_s = 1'b0;
        endcase
    end

    // Stage-1 pipeline registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            inside1_r <= 1'b0;
            blank1_r  <= 1'b0;
            digit1_r  <= 4'd0;
            col1_r    <= 3'd0;
            row1_r    <= 4'd0;
            color1_r  <= 8'd0;
        end else begin
            inside1_r <= inside_s;
            blank1_r  <= blank_s;
            digit1_r  <= digit_s;
            col1_r    <= col_s;
            row1_r    <= row_s;
            color1_r  <= color_s;
        end
    end

    // Stage-2 colour register, aligned with the ROM pixel register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            color2_r <= 8'd0;
        end else begin
            color2_r <= color1_r;
        end
    end

    score_glyph_rom u_glyph_rom (
        .clk     (clk),
        .resetN  (resetN),
        .visible (inside1_r & ~blank1_r),
        .digit   (digit1_r),
        .row     (row1_r),
        .col     (col1_r),
        .pixel   (pixel_s)
    );

    assign drawingRequest = pixel_s;
    assign RGBout         = pixel_s ? color2_r : 8'h00;

endmodule

// File: tb/tb_score_display_draw.sv
// Scoreboard bench for score_display_draw: each driven pixel pushes its expected output,
// which is popped and compared two clocks later. Flash checks run when SCORE_FLASH_EN is defined.
module tb_score_display_draw;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [3:0]  score1, score10, score100, score1000;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    score_display_draw dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .score1         (score1),
        .score10        (score10),
        .score100       (score100),
        .score1000      (score1000),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         dr;
        logic [7:0] rgb;
        string      tag;
    } exp_t;

    typedef struct {
        int    x;
        int    y;
        bit    lit;
        string tag;
    } vec_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           m_sh[4];
    int           m_cnt;
    logic [127:0] glyph_tb[10];

    function automatic logic [7:0] cur_color();
`ifdef SCORE_FLASH_EN
        if (m_cnt != 0 && (m_cnt & 4) != 0) return 8'hE0;
`endif
        return 8'hFF;
    endfunction

    function automatic bit model_lit(int x, int y);
        int x0, d, col, row;
        bit blank;
        if (y < 8 || y >= 40) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            x0 = 16 + 20 * i;
            if (x >= x0 && x < x0 + 16) begin
                d = (m_sh[i] > 9) ? 9 : m_sh[i];
                case (i)
                    0: blank = (m_sh[0] == 0);
                    1: blank = (m_sh[0] == 0) && (m_sh[1] == 0);
                    2: blank = (m_sh[0] == 0) && (m_sh[1] == 0) && (m_sh[2] == 0);
                    default: blank = 1'b0;
                endcase
                if (blank) return 1'b0;
                col = (x - x0) / 2;
                row = (y - 8) / 2;
                return glyph_tb[d][127 - (row * 8 + col)];
            end
        end
        return 1'b0;
    endfunction

    task automatic check(string name, logic a_dr, logic [7:0] a_rgb, bit e_dr, logic [7:0] e_rgb);
        checks++;
        if (a_dr !== e_dr || a_rgb !== e_rgb) begin
            errors++;
            $display("FAIL %s: got dr=%0b rgb=%h, want dr=%0b rgb=%h", name, a_dr, a_rgb, e_dr, e_rgb);
        end
    endtask

    // One pixel per clock; forced=1 uses the given expectation instead of the model
    task automatic drive(int x, int y, bit sof, bit forced, bit f_lit, logic [7:0] f_rgb, string tag);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check(e.tag, drawingRequest, RGBout, e.dr, e.rgb);
        end
        pixelX       = 11'(x);
        pixelY       = 11'(y);
        startOfFrame = sof;
        e.tag        = tag;
        if (!resetN) begin
            e.dr  = 1'b0;
            e.rgb = 8'h00;
        end else if (forced) begin
            e.dr  = f_lit;
            e.rgb = f_lit ? f_rgb : 8'h00;
        end else begin
            e.dr  = model_lit(x, y);
            e.rgb = e.dr ? cur_color() : 8'h00;
        end
        exp_q.push_back(e);
        if (sof && resetN) begin
            if (m_sh[0] != int'(score1000) || m_sh[1] != int'(score100) ||
                m_sh[2] != int'(score10) || m_sh[3] != int'(score1))
                m_cnt = 30;
            else if (m_cnt != 0)
                m_cnt = m_cnt - 1;
            m_sh[0] = int'(score1000);
            m_sh[1] = int'(score100);
            m_sh[2] = int'(score10);
            m_sh[3] = int'(score1);
        end
    endtask

    task automatic px(int x, int y, string tag);
        drive(x, y, 1'b0, 1'b0, 1'b0, 8'h00, tag);
    endtask

    task automatic sof_pulse();
        drive(0, 0, 1'b1, 1'b0, 1'b0, 8'h00, "sof");
    endtask

    task automatic scan(int x0, int x1, int y0, int y1, string tag);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                px(x, y, tag);
    endtask

    task automatic set_score(int d1000, int d100, int d10, int d1);
        score1000 = 4'(d1000);
        score100  = 4'(d100);
        score10   = 4'(d10);
        score1    = 4'(d1);
    endtask

    vec_t vecs[$];

    initial begin
        glyph_tb[0] = 128'h00003C66_666E7666_66666666_3C000000;
        glyph_tb[1] = 128'h00001838_78181818_18181818_7E000000;
        glyph_tb[2] = 128'h00003C66_06060C18_30606066_7E000000;
        glyph_tb[3] = 128'h00003C66_06061C06_06060666_3C000000;
        glyph_tb[4] = 128'h00000C1C_3C6CCCCC_FE0C0C0C_1E000000;
        glyph_tb[5] = 128'h00007E60_60607C06_06060666_3C000000;
        glyph_tb[6] = 128'h00001C30_60607C66_66666666_3C000000;
        glyph_tb[7] = 128'h00007E66_06060C18_18181818_18000000;
        glyph_tb[8] = 128'h00003C66_66663C66_66666666_3C000000;
        glyph_tb[9] = 128'h00003C66_66663E06_0606060C_38000000;

        // Hand-derived pixels for the "105" display
        vecs.push_back('{32, 20, 1'b0, "gap_32"});
        vecs.push_back('{52, 20, 1'b0, "gap_52"});
        vecs.push_back('{92, 20, 1'b0, "right_92"});
        vecs.push_back('{20, 7, 1'b0, "above_box"});
        vecs.push_back('{20, 40, 1'b0, "below_box"});
        vecs.push_back('{0, 0, 1'b0, "origin"});
        vecs.push_back('{2047, 20, 1'b0, "x_max"});
        vecs.push_back('{22, 12, 1'b0, "thou_blanked"});
        vecs.push_back('{42, 12, 1'b1, "hund_1_on"});
        vecs.push_back('{40, 12, 1'b0, "hund_1_off"});
        vecs.push_back('{60, 12, 1'b1, "tens_0_on"});
        vecs.push_back('{78, 12, 1'b1, "ones_5_on"});
        vecs.push_back('{76, 12, 1'b0, "ones_5_off"});

        for (int i = 0; i < 4; i++) m_sh[i] = 0;
        m_cnt        = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        pixelX       = 11'd0;
        pixelY       = 11'd0;
        set_score(0, 0, 0, 0);

        // Reset state
        px(80, 12, "in_reset");
        px(80, 12, "in_reset");
        px(80, 12, "in_reset");
        #1;
        check("reset_state", drawingRequest, RGBout, 1'b0, 8'h00);
        #6 resetN = 1'b1;

        // 1: power-up shows a single '0' in the ones box
        sof_pulse();
        scan(16, 91, 8, 39, "t1_zero");

        // 2: "105" with thousands blanked, tens '0' kept
        set_score(0, 1, 0, 5);
        sof_pulse();
        foreach (vecs[i])
            drive(vecs[i].x, vecs[i].y, 1'b0, 1'b1, vecs[i].lit, cur_color(), vecs[i].tag);
        scan(16, 91, 8, 39, "t2_105");

        // 3: mid-frame score change is held until the next frame
        set_score(0, 1, 0, 7);
        drive(86, 14, 1'b0, 1'b1, 1'b0, cur_color(), "t3_still_5");
        scan(76, 91, 8, 39, "t3_hold");
        sof_pulse();
        drive(86, 14, 1'b0, 1'b1, 1'b1, cur_color(), "t3_now_7");
        scan(76, 91, 8, 39, "t3_new");

        // 5: out-of-range thousands digit saturates to '9'
        set_score(12, 0, 0, 0);
        sof_pulse();
        drive(24, 30, 1'b0, 1'b1, 1'b1, cur_color(), "t5_nine_on");
        drive(18, 20, 1'b0, 1'b1, 1'b0, cur_color(), "t5_nine_off");
        scan(16, 91, 8, 39, "t5_9000");

        // Asynchronous reset while a lit pixel is on the outputs
        px(20, 12, "pre_rst");
        px(20, 12, "pre_rst");
        px(20, 12, "pre_rst");
        #2 resetN = 1'b0;
        #1;
        check("async_reset", drawingRequest, RGBout, 1'b0, 8'h00);
        foreach (exp_q[i]) begin
            exp_q[i].dr  = 1'b0;
            exp_q[i].rgb = 8'h00;
        end
        for (int i = 0; i < 4; i++) m_sh[i] = 0;
        m_cnt = 0;
        px(20, 12, "in_rst");
        px(20, 12, "in_rst");
        #7 resetN = 1'b1;
        drive(80, 12, 1'b0, 1'b1, 1'b1, 8'hFF, "post_rst_first");
        scan(16, 91, 8, 39, "post_rst_zero");

`ifdef SCORE_FLASH_EN
        // 6: flash colour follows bit 2 of a 30-frame countdown, then steady
        set_score(0, 0, 0, 3);
        sof_pulse();
        for (int k = 0; k < 34; k++) begin
            drive(80, 12, 1'b0, 1'b1, 1'b1,
                  (k < 30 && ((30 - k) & 4) != 0) ? 8'hE0 : 8'hFF, "t6_flash");
            sof_pulse();
        end
`endif

        px(0, 0, "drain");
        px(0, 0, "drain");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
